// File: rtl/board_scan_arbiter.sv
// Arbitrates the single chessboard pattern-read port between the win checker (0)
// and the AI move scorer (1); one whole scan per grant, with a watchdog for hung scanners.
module board_scan_arbiter #(
  parameter int unsigned BOARD_SIZE = 15,
  parameter int unsigned TIMEOUT    = 512,
  parameter int unsigned TO_W       = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       req0,
  input  logic       req1,
  input  logic [3:0] i0,
  input  logic [3:0] j0,
  input  logic [3:0] i1,
  input  logic [3:0] j1,
  input  logic       done0,
  input  logic       done1,
  output logic       gnt0,
  output logic       gnt1,
  output logic [3:0] get_i,
  output logic [3:0] get_j,
  output logic       busy,
  output logic       timeout_err
);

  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t          state, state_nxt;
  logic [TO_W-1:0] wdog, wdog_nxt, wdog_inc;
  logic            wdog_hit;
  logic            last, last_nxt;
  logic            gnt0_nxt, gnt1_nxt, busy_nxt, terr_nxt;
  logic            rel_normal;

  // Off-board coordinates read square (0,0) rather than aliasing.
  function automatic logic [CW-1:0] clamp(input logic [CW-1:0] c);
    return (32'(c) < BOARD_SIZE) ? c : '0;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      wdog        <= '0;
      last        <= 1'b1;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      wdog        <= wdog_nxt;
      last        <= last_nxt;
      gnt0        <= gnt0_nxt;
      gnt1        <= gnt1_nxt;
      busy        <= busy_nxt;
      timeout_err <= terr_nxt;
    end
  end

  // Next state, watchdog and round-robin bookkeeping.
  always_comb begin
    state_nxt  = state;
    wdog_nxt   = '0;
    last_nxt   = last;
    terr_nxt   = timeout_err;
    rel_normal = 1'b0;
    wdog_hit   = (wdog == TO_W'(TIMEOUT - 1));
    wdog_inc   = (&wdog) ? wdog : wdog + TO_W'(1);

    case (state)
      IDLE: begin
        if (req0 && req1)  state_nxt = last ? OWN0 : OWN1;
        else if (req0)     state_nxt = OWN0;
        else if (req1)     state_nxt = OWN1;
      end
      OWN0: begin
        rel_normal = done0 || !req0;
        if (rel_normal || wdog_hit) begin
          state_nxt = IDLE;
          last_nxt  = 1'b0;
          if (!rel_normal) terr_nxt = 1'b1;
        end else begin
          wdog_nxt = wdog_inc;
        end
      end
      OWN1: begin
        rel_normal = done1 || !req1;
        if (rel_normal || wdog_hit) begin
          state_nxt = IDLE;
          last_nxt  = 1'b1;
          if (!rel_normal) terr_nxt = 1'b1;
        end else begin
          wdog_nxt = wdog_inc;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (clr) begin
      state_nxt = IDLE;
      wdog_nxt  = '0;
      last_nxt  = 1'b1;
      terr_nxt  = 1'b0;
    end

    gnt0_nxt = (state_nxt == OWN0);
    gnt1_nxt = (state_nxt == OWN1);
    busy_nxt = (state_nxt != IDLE);
  end

  // Board coordinates follow the current owner; zero while idle.
  always_comb begin
    get_i = '0;
    get_j = '0;
    case (state)
      OWN0: begin
        get_i = clamp(i0);
        get_j = clamp(j0);
      end
      OWN1: begin
        get_i = clamp(i1);
        get_j = clamp(j1);
      end
      default: begin
        get_i = '0;
        get_j = '0;
      end
    endcase
  end

endmodule
